// File: rtl/snax_csr_pkg.sv
// Shared definitions for the SNAX CSR manager: FSM states, status bit layout and
// address map helpers derived from the number of RW CSRs.
package snax_csr_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StLaunch
  } state_e;

  // STATUS word: bit 0 is "launch pending", all other bits read as zero.
  localparam int unsigned StatusLaunchBit = 0;

  // Last RW CSR doubles as the START register.
  function automatic logic [31:0] start_addr(int unsigned num_rw);
    return 32'(num_rw - 1);
  endfunction

  // STATUS sits directly after the RW block.
  function automatic logic [31:0] status_addr(int unsigned num_rw);
    return 32'(num_rw);
  endfunction

  // Read-only accelerator status words follow STATUS.
  function automatic logic [31:0] ro_base(int unsigned num_rw);
    return 32'(num_rw + 1);
  endfunction

endpackage

// File: rtl/snax_csr_manager_if.sv
// CSR request/response bus between a host (master) and the CSR manager (slave).
interface snax_csr_manager_if;

  logic [31:0] req_bits_data;
  logic [31:0] req_bits_addr;
  logic        req_bits_write;
  logic        req_valid;
  logic        req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_bits_data;

  modport master (
    output req_bits_data, req_bits_addr, req_bits_write, req_valid, rsp_ready,
    input  req_ready, rsp_valid, rsp_bits_data
  );

  modport slave (
    input  req_bits_data, req_bits_addr, req_bits_write, req_valid, rsp_ready,
    output req_ready, rsp_valid, rsp_bits_data
  );

endinterface

// File: rtl/snax_csr_rsp_reg.sv
// One-entry valid/ready holding register for CSR read responses.
module snax_csr_rsp_reg #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o,
  output logic             free_o
);

  logic             valid_q, valid_d;
  logic [Width-1:0] data_q, data_d;

  // Load wins over drain so back-to-back reads keep full throughput.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
      data_d  = '0;
    end
  end

  // Response state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign free_o  = !valid_q || ready_i;

endmodule

// File: rtl/snax_csr_manager.sv
// CSR manager: RW config registers, STATUS and RO status words behind a
// valid/ready CSR bus, plus a launch handshake that hands a config snapshot
// to the accelerator when START is written.
module snax_csr_manager
  import snax_csr_pkg::*;
#(
  parameter int unsigned NumRwCsr = 8,
  parameter int unsigned NumRoCsr = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  snax_csr_manager_if.slave          csr_io,
  output logic [NumRwCsr-1:0][31:0]  cfg_data_o,
  output logic                       cfg_valid_o,
  input  logic                       cfg_ready_i,
  input  logic [NumRoCsr-1:0][31:0]  ro_csr_i
);

  localparam logic [31:0] StartAddr  = start_addr(NumRwCsr);
  localparam logic [31:0] StatusAddr = status_addr(NumRwCsr);
  localparam logic [31:0] RoBase     = ro_base(NumRwCsr);

  state_e                     state_q, state_d;
  logic [NumRwCsr-1:0][31:0]  csr_q, csr_d;
  logic [NumRwCsr-1:0][31:0]  cfg_q, cfg_d;
  logic                       is_start, rd_free;
  logic                       wr_fire, rd_fire, launch_fire;
  logic [31:0]                rd_data;

  assign is_start = (csr_io.req_bits_addr == StartAddr);

  // Ready never looks at req_valid: START stalls while a launch is pending,
  // reads stall only while the response slot is occupied and not draining.
  assign csr_io.req_ready = csr_io.req_bits_write ? !(is_start && state_q == StLaunch)
                                                  : rd_free;

  assign wr_fire     = csr_io.req_valid && csr_io.req_ready && csr_io.req_bits_write;
  assign rd_fire     = csr_io.req_valid && csr_io.req_ready && !csr_io.req_bits_write;
  assign launch_fire = wr_fire && is_start && (state_q == StIdle);

  // Read data mux over the address map; unmapped addresses read as zero.
  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < NumRwCsr; i++) begin
      if (csr_io.req_bits_addr == i) rd_data = csr_q[i];
    end
    if (csr_io.req_bits_addr == StatusAddr) rd_data[StatusLaunchBit] = (state_q == StLaunch);
    for (int unsigned i = 0; i < NumRoCsr; i++) begin
      if (csr_io.req_bits_addr == RoBase + i) rd_data = ro_csr_i[i];
    end
  end

  // Next-state for RW CSRs, launch snapshot and FSM.
  always_comb begin
    csr_d   = csr_q;
    cfg_d   = cfg_q;
    state_d = state_q;
    if (wr_fire) begin
      for (int unsigned i = 0; i < NumRwCsr; i++) begin
        if (csr_io.req_bits_addr == i) csr_d[i] = csr_io.req_bits_data;
      end
    end
    unique case (state_q)
      StIdle: begin
        if (launch_fire) begin
          state_d = StLaunch;
          // csr_d already carries the START write data in the last slot.
          cfg_d   = csr_d;
        end
      end
      StLaunch: begin
        if (cfg_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      csr_q   <= '0;
      cfg_q   <= '0;
    end else begin
      state_q <= state_d;
      csr_q   <= csr_d;
      cfg_q   <= cfg_d;
    end
  end

  assign cfg_data_o  = cfg_q;
  assign cfg_valid_o = (state_q == StLaunch);

  snax_csr_rsp_reg #(
    .Width (32)
  ) u_rsp_reg (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (rd_fire),
    .data_i  (rd_data),
    .ready_i (csr_io.rsp_ready),
    .valid_o (csr_io.rsp_valid),
    .data_o  (csr_io.rsp_bits_data),
    .free_o  (rd_free)
  );

endmodule

// File: tb/tb_snax_csr_manager.sv
// Scoreboard bench for snax_csr_manager: a reference model updated on the
// falling edge predicts ready, responses and launch outputs; a separate
// monitor pops expected read data whenever a response handshake happens.
module tb_snax_csr_manager;

  localparam int unsigned NumRw = 8;
  localparam int unsigned NumRo = 2;
  localparam logic [31:0] StartA  = 32'(NumRw - 1);
  localparam logic [31:0] StatusA = 32'(NumRw);
  localparam logic [31:0] RoBaseA = 32'(NumRw + 1);
  localparam logic [31:0] UnmapA  = 32'(NumRw + NumRo + 1);

  logic                    clk_i = 1'b0;
  logic                    rst_i = 1'b1;
  logic                    cfg_ready;
  logic                    cfg_valid;
  logic [NumRw-1:0][31:0]  cfg_data;
  logic [NumRo-1:0][31:0]  ro_csr;

  bit rand_rdy = 1'b0;
  bit cfg_ready_dir = 1'b0, cfg_ready_rnd = 1'b0;
  bit rsp_ready_dir = 1'b1, rsp_ready_rnd = 1'b0;

  snax_csr_manager_if csr_bus ();

  assign cfg_ready         = rand_rdy ? cfg_ready_rnd : cfg_ready_dir;
  assign csr_bus.rsp_ready = rand_rdy ? rsp_ready_rnd : rsp_ready_dir;

  snax_csr_manager #(
    .NumRwCsr (NumRw),
    .NumRoCsr (NumRo)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .csr_io      (csr_bus),
    .cfg_data_o  (cfg_data),
    .cfg_valid_o (cfg_valid),
    .cfg_ready_i (cfg_ready),
    .ro_csr_i    (ro_csr)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic check32(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic checkv(string name, logic [NumRw*32-1:0] act, logic [NumRw*32-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model state.
  logic [31:0] m_csr [NumRw];
  logic [31:0] m_cfg [NumRw];
  bit          m_launch;
  bit          m_rsp_pend;
  logic [31:0] sb [$];
  bit          acc_flag;

  function automatic logic [31:0] model_read(logic [31:0] a);
    if (a < NumRw) return m_csr[a];
    if (a == StatusA) return {31'b0, m_launch};
    if (a >= RoBaseA && a < RoBaseA + NumRo) return ro_csr[a - RoBaseA];
    return 32'h0;
  endfunction

  // Model: check outputs against the current model, then advance it one edge.
  always @(negedge clk_i) begin
    logic [NumRw-1:0][31:0] exp_cfg;
    bit exp_ready, acc, nxt_launch, nxt_pend;
    if (rst_i) begin
      m_launch   = 1'b0;
      m_rsp_pend = 1'b0;
      for (int i = 0; i < NumRw; i++) begin
        m_csr[i] = '0;
        m_cfg[i] = '0;
      end
      sb.delete();
      acc_flag = 1'b0;
      check32("rst_cfg_valid", {31'b0, cfg_valid}, 32'h0);
      check32("rst_rsp_valid", {31'b0, csr_bus.rsp_valid}, 32'h0);
      check32("rst_rsp_data", csr_bus.rsp_bits_data, 32'h0);
      checkv("rst_cfg_data", cfg_data, '0);
    end else begin
      for (int i = 0; i < NumRw; i++) exp_cfg[i] = m_cfg[i];
      if (csr_bus.req_bits_write)
        exp_ready = !(csr_bus.req_bits_addr == StartA && m_launch);
      else
        exp_ready = !m_rsp_pend || csr_bus.rsp_ready;
      check32("req_ready", {31'b0, csr_bus.req_ready}, {31'b0, exp_ready});
      check32("cfg_valid", {31'b0, cfg_valid}, {31'b0, m_launch});
      check32("rsp_valid", {31'b0, csr_bus.rsp_valid}, {31'b0, m_rsp_pend});
      checkv("cfg_data", cfg_data, exp_cfg);

      acc        = csr_bus.req_valid && exp_ready;
      nxt_launch = m_launch && !cfg_ready;
      nxt_pend   = m_rsp_pend && !csr_bus.rsp_ready;
      if (acc && !csr_bus.req_bits_write) begin
        sb.push_back(model_read(csr_bus.req_bits_addr));
        nxt_pend = 1'b1;
      end
      if (acc && csr_bus.req_bits_write) begin
        if (csr_bus.req_bits_addr < NumRw) m_csr[csr_bus.req_bits_addr] = csr_bus.req_bits_data;
        if (csr_bus.req_bits_addr == StartA && !m_launch) begin
          nxt_launch = 1'b1;
          for (int i = 0; i < NumRw; i++) m_cfg[i] = m_csr[i];
        end
      end
      m_launch   = nxt_launch;
      m_rsp_pend = nxt_pend;
      acc_flag   = acc;
    end
  end

  // Monitor: every response handshake must match the oldest expected read.
  always @(negedge clk_i) begin
    if (!rst_i && csr_bus.rsp_valid && csr_bus.rsp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected actual=%h required=none", csr_bus.rsp_bits_data);
      end else begin
        check32("rsp_data", csr_bus.rsp_bits_data, sb.pop_front());
      end
    end
  end

  // Background drivers for RO status words and randomised ready signals.
  initial begin
    ro_csr = '0;
    forever begin
      @(posedge clk_i);
      #1;
      ro_csr        = {$urandom, $urandom};
      cfg_ready_rnd = ($urandom_range(0, 2) == 0);
      rsp_ready_rnd = $urandom_range(0, 1) != 0;
    end
  end

  task automatic send(bit w, logic [31:0] a, logic [31:0] d);
    int n = 0;
    csr_bus.req_bits_write = w;
    csr_bus.req_bits_addr  = a;
    csr_bus.req_bits_data  = d;
    csr_bus.req_valid      = 1'b1;
    do begin
      @(posedge clk_i);
      n++;
    end while (!acc_flag && n < 300);
    #1;
    csr_bus.req_valid = 1'b0;
    checks++;
    if (!acc_flag) begin
      errors++;
      $display("FAIL req_timeout actual=stalled required=accepted addr=%h", a);
    end
  endtask

  task automatic cycles(int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  initial begin
    csr_bus.req_valid      = 1'b0;
    csr_bus.req_bits_write = 1'b0;
    csr_bus.req_bits_addr  = '0;
    csr_bus.req_bits_data  = '0;

    #2;
    check32("init_cfg_valid", {31'b0, cfg_valid}, 32'h0);
    check32("init_rsp_valid", {31'b0, csr_bus.rsp_valid}, 32'h0);
    checkv("init_cfg_data", cfg_data, '0);
    cycles(2);
    rst_i = 1'b0;
    cycles(1);

    // Simple write then read back.
    send(1'b1, 32'd2, 32'hA5);
    send(1'b0, 32'd2, 32'h0);
    cycles(2);

    // Launch held for 5 cycles, STATUS reflects pending launch, then release.
    send(1'b1, StartA, 32'h1);
    cycles(5);
    send(1'b0, StatusA, 32'h0);
    cfg_ready_dir = 1'b1;
    cycles(1);
    cfg_ready_dir = 1'b0;
    send(1'b0, StatusA, 32'h0);

    // Writes during launch: CSR 0 updates, START stalls until after handshake.
    send(1'b1, StartA, 32'h3);
    send(1'b1, 32'd0, 32'h7);
    fork
      send(1'b1, StartA, 32'h5);
      begin
        cycles(3);
        cfg_ready_dir = 1'b1;
        cycles(1);
        cfg_ready_dir = 1'b0;
      end
    join
    send(1'b0, 32'd0, 32'h0);
    cfg_ready_dir = 1'b1;
    cycles(1);
    cfg_ready_dir = 1'b0;

    // Back-to-back reads against a stalled response channel.
    rsp_ready_dir = 1'b0;
    fork
      begin
        send(1'b0, 32'd2, 32'h0);
        send(1'b0, 32'd0, 32'h0);
      end
      begin
        cycles(4);
        rsp_ready_dir = 1'b1;
      end
    join
    cycles(2);

    // Unmapped address: reads zero, writes have no effect.
    send(1'b0, UnmapA, 32'h0);
    send(1'b1, UnmapA, 32'hDEAD_BEEF);
    send(1'b1, StatusA, 32'hFFFF_FFFF);
    send(1'b1, RoBaseA, 32'h1234_5678);
    for (int i = 0; i < NumRw; i++) send(1'b0, 32'(i), 32'h0);
    send(1'b0, StatusA, 32'h0);
    send(1'b0, RoBaseA + 32'd1, 32'h0);

    // Randomised traffic with random ready behaviour.
    rand_rdy = 1'b1;
    repeat (400) begin
      logic [31:0] a;
      a = ($urandom_range(0, 9) < 2) ? StartA : 32'($urandom_range(0, NumRw + NumRo + 2));
      send($urandom_range(0, 1) != 0, a, $urandom);
      if ($urandom_range(0, 3) == 0) cycles(1);
    end
    rand_rdy      = 1'b0;
    cfg_ready_dir = 1'b1;
    rsp_ready_dir = 1'b1;
    cycles(3);
    cfg_ready_dir = 1'b0;

    // Asynchronous reset during launch with a response pending.
    send(1'b1, StartA, 32'h9);
    rsp_ready_dir = 1'b0;
    send(1'b0, 32'd3, 32'h0);
    #2;
    rst_i = 1'b1;
    #1;
    check32("async_cfg_valid", {31'b0, cfg_valid}, 32'h0);
    check32("async_rsp_valid", {31'b0, csr_bus.rsp_valid}, 32'h0);
    checkv("async_cfg_data", cfg_data, '0);
    cycles(2);
    rst_i = 1'b0;
    rsp_ready_dir = 1'b1;
    cycles(2);
    send(1'b0, StartA, 32'h0);
    send(1'b0, StatusA, 32'h0);
    cycles(3);
    check32("sb_drained", 32'(sb.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
